instr_loader: RTL and testbench

Writes a program image into the 64 x 20-bit instruction BRAM that the processor core fetches from. It sits on the BRAM write port, between a byte-stream receiver (UART RX) and the memory. It deframes the incoming bytes, assembles 20-bit instruction words and writes them to sequential addresses. It holds the core in reset (`cpu_hold`) until a complete, checksum-valid image has been written.

---
 rtl/instr_loader_if.sv | 25 ++
 rtl/instr_loader.sv | 175 +++++++++++++++++
 tb/tb_instr_loader.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/instr_loader_if.sv
// Byte-stream input and BRAM write port of the instruction loader.
// The loader drives the write port (master) and receives the byte stream from the UART side.
interface instr_loader_if;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        wea;
    logic [5:0]  addra;
    logic [19:0] dina;

    modport master (
        input  rx_data,
        input  rx_valid,
        output wea,
        output addra,
        output dina
    );

    modport slave (
        output rx_data,
        output rx_valid,
        input  wea,
        input  addra,
        input  dina
    );
endinterface

// File: rtl/instr_loader.sv
// Deframes a UART byte stream into 20-bit instruction words and writes them to the
// instruction BRAM, holding the core in reset until a checksum-valid image is loaded.
module instr_loader #(
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int unsigned DEPTH    = 64
) (
    input  logic           clka,
    input  logic           rst_n,
    instr_loader_if.master bus,
    input  logic           start,
    output logic           busy,
    output logic           done,
    output logic           err,
    output logic           cpu_hold,
    output logic [6:0]     word_count
);

    localparam int unsigned AW = 6;
    localparam int unsigned DW = 20;
    localparam int unsigned CW = 7;
    localparam int unsigned BW = 8;
    localparam logic [AW-1:0] ADDR_MAX = AW'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_HDR,
        S_LEN,
        S_W0,
        S_W1,
        S_W2,
        S_CHK,
        S_DONE,
        S_ERR
    } state_t;

    state_t          state;
    state_t          state_nxt;

    logic            ld_len;
    logic            ld_b0;
    logic            ld_b1;
    logic            ld_b2;
    logic            last_word_c;
    logic            len_bad_c;

    logic [CW-1:0]   n_len;
    logic [BW-1:0]   csum;
    logic [3:0]      b0_nib;
    logic [BW-1:0]   b1_q;
    logic            wea_q;
    logic [AW-1:0]   addra_q;
    logic [DW-1:0]   dina_q;

    assign bus.wea   = wea_q;
    assign bus.addra = addra_q;
    assign bus.dina  = dina_q;

    assign last_word_c = (CW'(word_count + CW'(1)) == n_len);
    assign len_bad_c   = (bus.rx_data == '0) || (32'(bus.rx_data) > DEPTH);

    // State register
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) state <= S_HDR;
        else        state <= state_nxt;
    end

    // Next-state and byte-accept decode
    always_comb begin
        state_nxt = state;
        ld_len    = 1'b0;
        ld_b0     = 1'b0;
        ld_b1     = 1'b0;
        ld_b2     = 1'b0;
        case (state)
            S_HDR: begin
                if (bus.rx_valid && (bus.rx_data == HDR_BYTE)) state_nxt = S_LEN;
            end
            S_LEN: begin
                if (bus.rx_valid) begin
                    if (len_bad_c) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_W0;
                        ld_len    = 1'b1;
                    end
                end
            end
            S_W0: begin
                if (bus.rx_valid) begin
                    if (bus.rx_data[7:4] != 4'd0) begin
                        state_nxt = S_ERR;
                    end else begin
                        state_nxt = S_W1;
                        ld_b0     = 1'b1;
                    end
                end
            end
            S_W1: begin
                if (bus.rx_valid) begin
                    state_nxt = S_W2;
                    ld_b1     = 1'b1;
                end
            end
            S_W2: begin
                if (bus.rx_valid) begin
                    state_nxt = last_word_c ? S_CHK : S_W0;
                    ld_b2     = 1'b1;
                end
            end
            S_CHK: begin
                if (bus.rx_valid) state_nxt = (bus.rx_data == csum) ? S_DONE : S_ERR;
            end
            S_DONE, S_ERR: begin
                if (start) state_nxt = S_HDR;
            end
            default: state_nxt = S_HDR;
        endcase
    end

    // Word assembly, running checksum and write port
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            wea_q      <= 1'b0;
            addra_q    <= '0;
            dina_q     <= '0;
            n_len      <= '0;
            csum       <= '0;
            b0_nib     <= '0;
            b1_q       <= '0;
            word_count <= '0;
        end else begin
            wea_q <= ld_b2;
            if (ld_len) begin
                n_len      <= CW'(bus.rx_data);
                csum       <= bus.rx_data;
                addra_q    <= '0;
                word_count <= '0;
            end
            if (ld_b0) begin
                csum   <= csum ^ bus.rx_data;
                b0_nib <= bus.rx_data[3:0];
            end
            if (ld_b1) begin
                csum <= csum ^ bus.rx_data;
                b1_q <= bus.rx_data;
            end
            if (ld_b2) begin
                csum   <= csum ^ bus.rx_data;
                dina_q <= {b0_nib, b1_q, bus.rx_data};
            end
            // Advance after the write pulse; the address saturates at the top of memory
            if (wea_q) begin
                word_count <= CW'(word_count + CW'(1));
                if (addra_q != ADDR_MAX) addra_q <= AW'(addra_q + AW'(1));
            end
            if ((state == S_DONE) && start) word_count <= '0;
        end
    end

    // Status flags follow the state being entered
    always_ff @(posedge clka or negedge rst_n) begin
        if (!rst_n) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            cpu_hold <= 1'b1;
        end else begin
            busy     <= (state_nxt == S_LEN) || (state_nxt == S_W0) || (state_nxt == S_W1) ||
                        (state_nxt == S_W2)  || (state_nxt == S_CHK);
            done     <= (state_nxt == S_DONE);
            err      <= (state_nxt == S_ERR);
            cpu_hold <= (state_nxt != S_DONE);
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: directed frames from the test plan plus randomized
// frames, checked against a frame-level model of the expected writes and final status.
module tb_instr_loader;

    logic       clka = 1'b0;
    logic       rst_n;
    logic       start;
    logic       busy;
    logic       done;
    logic       err;
    logic       cpu_hold;
    logic [6:0] word_count;

    instr_loader_if bus ();

    instr_loader #(.HDR_BYTE(8'hA5), .DEPTH(64)) dut (
        .clka       (clka),
        .rst_n      (rst_n),
        .bus        (bus.master),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .cpu_hold   (cpu_hold),
        .word_count (word_count)
    );

    always #5 clka = ~clka;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [25:0] got_q[$];
    logic [25:0] expw[$];
    logic [7:0]  fr[$];
    logic [19:0] wq[$];
    logic [7:0]  bad_b0 = 8'h10;
    bit          exp_done;
    bit          exp_err;
    int          md_wc   = 0;
    int          md_addr = 0;

    // Write-port monitor: every cycle with wea high is one BRAM write
    always @(negedge clka) begin
        if (bus.wea === 1'b1) got_q.push_back({bus.addra, bus.dina});
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // Frame-level model: bytes to send, writes expected, final status expected
    task automatic build(input int len_byte, input int bad_at, input bit bad_cs);
        logic [7:0] x;
        logic [7:0] b0;
        logic [7:0] b1;
        logic [7:0] b2;
        fr.delete();
        expw.delete();
        fr.push_back(8'hA5);
        fr.push_back(8'(len_byte));
        exp_done = 1'b0;
        exp_err  = 1'b0;
        if (len_byte < 1 || len_byte > 64) begin
            exp_err = 1'b1;
            fr.push_back(8'h5A);
            return;
        end
        md_wc   = 0;
        md_addr = 0;
        x       = 8'(len_byte);
        for (int k = 0; k < len_byte; k++) begin
            if (k == bad_at) begin
                fr.push_back(bad_b0);
                fr.push_back(8'h33);
                exp_err = 1'b1;
                return;
            end
            b0 = {4'h0, wq[k][19:16]};
            b1 = wq[k][15:8];
            b2 = wq[k][7:0];
            fr.push_back(b0);
            fr.push_back(b1);
            fr.push_back(b2);
            x = x ^ b0 ^ b1 ^ b2;
            expw.push_back({6'(md_addr), wq[k]});
            md_wc++;
            if (md_addr < 63) md_addr++;
        end
        fr.push_back(bad_cs ? (x ^ 8'h01) : x);
        exp_done = !bad_cs;
        exp_err  = bad_cs;
    endtask

    task automatic rand_words(input int n);
        wq.delete();
        for (int k = 0; k < n; k++) wq.push_back(20'($urandom));
    endtask

    task automatic run(input int start_at, input bit b2b);
        foreach (fr[i]) begin
            @(negedge clka);
            bus.rx_data  = fr[i];
            bus.rx_valid = 1'b1;
            start        = (i == start_at);
            if (!b2b) begin
                @(negedge clka);
                bus.rx_valid = 1'b0;
                start        = 1'b0;
            end
        end
        @(negedge clka);
        bus.rx_valid = 1'b0;
        start        = 1'b0;
    endtask

    task automatic check_end(input string tag);
        chk({tag, ".done"},     32'(done),     32'(exp_done));
        chk({tag, ".err"},      32'(err),      32'(exp_err));
        chk({tag, ".busy"},     32'(busy),     32'd0);
        chk({tag, ".cpu_hold"}, 32'(cpu_hold), 32'(!exp_done));
        repeat (3) @(negedge clka);
        chk({tag, ".nwrites"}, 32'(got_q.size()), 32'(expw.size()));
        foreach (expw[i]) begin
            if (i < got_q.size()) chk({tag, ".write"}, 32'(got_q[i]), 32'(expw[i]));
        end
        chk({tag, ".word_count"}, 32'(word_count), 32'(md_wc));
        chk({tag, ".addra"},      32'(bus.addra),  32'(md_addr));
        got_q.delete();
    endtask

    task automatic rearm(input string tag);
        bit was_done;
        was_done = exp_done;
        @(negedge clka);
        start = 1'b1;
        @(negedge clka);
        start = 1'b0;
        if (was_done) md_wc = 0;
        chk({tag, ".rearm.done"},     32'(done),       32'd0);
        chk({tag, ".rearm.err"},      32'(err),        32'd0);
        chk({tag, ".rearm.cpu_hold"}, 32'(cpu_hold),   32'd1);
        chk({tag, ".rearm.wc"},       32'(word_count), 32'(md_wc));
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, ".wea"},      32'(bus.wea),    32'd0);
        chk({tag, ".addra"},    32'(bus.addra),  32'd0);
        chk({tag, ".dina"},     32'(bus.dina),   32'd0);
        chk({tag, ".busy"},     32'(busy),       32'd0);
        chk({tag, ".done"},     32'(done),       32'd0);
        chk({tag, ".err"},      32'(err),        32'd0);
        chk({tag, ".wc"},       32'(word_count), 32'd0);
        chk({tag, ".cpu_hold"}, 32'(cpu_hold),   32'd1);
    endtask

    initial begin
        int kind;
        int len;
        int sa;
        logic [7:0] g;

        rst_n        = 1'b0;
        start        = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        repeat (2) @(negedge clka);
        chk_reset_values("reset");
        rst_n = 1'b1;

        // Good 2-word frame, spaced bytes
        wq.delete();
        wq.push_back(20'h12345);
        wq.push_back(20'hF00FF);
        build(2, -1, 1'b0);
        run(-1, 1'b0);
        check_end("good2");
        rearm("good2");

        // Same frame, bad checksum, back-to-back bytes
        build(2, -1, 1'b1);
        run(-1, 1'b1);
        check_end("badcs");
        rearm("badcs");

        build(0, -1, 1'b0);
        run(-1, 1'b1);
        check_end("len0");
        rearm("len0");

        build(65, -1, 1'b0);
        run(-1, 1'b1);
        check_end("len65");
        rearm("len65");

        rand_words(2);
        bad_b0 = 8'h10;
        build(2, 0, 1'b0);
        run(-1, 1'b1);
        check_end("illegal_b0");
        rearm("illegal_b0");

        // Full depth, word k = k, back-to-back
        wq.delete();
        for (int k = 0; k < 64; k++) wq.push_back(20'(k));
        build(64, -1, 1'b0);
        run(-1, 1'b1);
        check_end("full");
        rearm("full");

        // Garbage before header, start pulse mid-frame
        rand_words(3);
        build(3, -1, 1'b0);
        fr.push_front(8'hFF);
        fr.push_front(8'h00);
        run(6, 1'b0);
        check_end("garbage_start");
        rearm("garbage_start");

        // Reset after b1 of word 3
        rand_words(5);
        build(5, -1, 1'b0);
        while (fr.size() > 13) void'(fr.pop_back());
        while (expw.size() > 3) void'(expw.pop_back());
        run(-1, 1'b1);
        chk("midframe.busy",     32'(busy),     32'd1);
        chk("midframe.cpu_hold", 32'(cpu_hold), 32'd1);
        @(negedge clka);
        rst_n = 1'b0;
        #1;
        chk_reset_values("midreset");
        repeat (3) @(negedge clka);
        rst_n = 1'b1;
        repeat (3) @(negedge clka);
        chk("midreset.nwrites", 32'(got_q.size()), 32'd3);
        foreach (expw[i]) begin
            if (i < got_q.size()) chk("midreset.write", 32'(got_q[i]), 32'(expw[i]));
        end
        got_q.delete();
        md_wc   = 0;
        md_addr = 0;

        rand_words(4);
        build(4, -1, 1'b0);
        run(-1, 1'b1);
        check_end("after_reset");
        rearm("after_reset");

        // Randomized frames
        for (int it = 0; it < 25; it++) begin
            kind = int'($urandom_range(0, 3));
            len  = int'($urandom_range(1, 64));
            rand_words(len);
            bad_b0 = {4'($urandom_range(1, 15)), 4'($urandom_range(0, 15))};
            sa = -1;
            case (kind)
                0: build(len, -1, 1'b0);
                1: build(len, -1, 1'b1);
                2: build(len, int'($urandom_range(0, len - 1)), 1'b0);
                default: build(($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(65, 255)), -1, 1'b0);
            endcase
            if (kind <= 1 && $urandom_range(0, 1) == 1) sa = int'($urandom_range(2, fr.size() - 2));
            g = 8'($urandom);
            if (g == 8'hA5) g = 8'h00;
            if ($urandom_range(0, 1) == 1) begin
                fr.push_front(g);
                if (sa >= 0) sa++;
            end
            run(sa, 1'($urandom_range(0, 1)));
            check_end("rand");
            rearm("rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
